// File: rtl/actuator_guard_pkg.sv
// Shared types and defaults for the actuator guard.
// Optional fault counter is enabled by defining ACTUATOR_GUARD_FAULT_CNT_EN.
package actuator_guard_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDead = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      DevNone   = 2'd0,
      DevHeater = 2'd1,
      DevCooler = 2'd2,
      DevAc     = 2'd3
   } device_e;

   localparam int unsigned DefaultMinOnCycles = 16;
   localparam int unsigned DefaultDeadCycles  = 8;

   // Request vector bit order: [0] heater, [1] cooler, [2] ac.
   function automatic logic [2:0] dev_mask(input device_e dev);
      unique case (dev)
         DevHeater: dev_mask = 3'b001;
         DevCooler: dev_mask = 3'b010;
         DevAc:     dev_mask = 3'b100;
         default:   dev_mask = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/actuator_guard_timer.sv
// 8-bit loadable down counter that saturates at zero; done while the count is zero.
module actuator_guard_timer (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       en_i,
   output logic       done_o
);

   logic [7:0] count_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= 8'd0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != 8'd0)) begin
         count_q <= count_q - 8'd1;
      end
   end

   assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/actuator_guard.sv
// Mutually exclusive actuator drive with minimum on-time and dead time between drives.
// Define ACTUATOR_GUARD_FAULT_CNT_EN to add the saturating fault_count output.
module actuator_guard
   import actuator_guard_pkg::*;
#(
   parameter int unsigned MIN_ON_CYCLES = DefaultMinOnCycles,
   parameter int unsigned DEAD_CYCLES   = DefaultDeadCycles
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       heater_req,
   input  logic       ac_req,
   input  logic       cooler_req,
   output logic       heater_drive,
   output logic       ac_drive,
   output logic       cooler_drive,
   output logic       busy,
`ifdef ACTUATOR_GUARD_FAULT_CNT_EN
   output logic [7:0] fault_count,
`endif
   output logic       multi_req_err
);

   // The timer counts down to zero, so load one less than the wanted cycle count.
   localparam logic [7:0] MinOnLoad = 8'(MIN_ON_CYCLES - 1);
   localparam logic [7:0] DeadLoad  = 8'(DEAD_CYCLES - 1);

   state_e     state_q;
   device_e    dev_q;
   device_e    req_dev;
   logic       heater_q, ac_q, cooler_q, busy_q, err_q;
   logic [2:0] req;
   logic       one_req, multi_req, sel_req, other_req, run_exit;
   logic       tmr_load, tmr_en, tmr_done;
   logic [7:0] tmr_val;

   assign req       = {ac_req, cooler_req, heater_req};
   assign one_req   = $onehot(req);
   assign multi_req = (req != 3'b000) && !one_req;
   assign sel_req   = |(req & dev_mask(dev_q));
   assign other_req = |(req & ~dev_mask(dev_q));
   assign run_exit  = (state_q == StRun) && tmr_done && (!sel_req || other_req);

   always_comb begin
      req_dev = DevNone;
      unique case (req)
         3'b001:  req_dev = DevHeater;
         3'b010:  req_dev = DevCooler;
         3'b100:  req_dev = DevAc;
         default: req_dev = DevNone;
      endcase
   end

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = 8'd0;
      tmr_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            tmr_load = one_req;
            tmr_val  = MinOnLoad;
         end
         StRun: begin
            tmr_load = run_exit;
            tmr_val  = DeadLoad;
            tmr_en   = !run_exit;
         end
         StDead:  tmr_en = 1'b1;
         default: tmr_en = 1'b0;
      endcase
   end

   actuator_guard_timer u_timer (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .done_o     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         dev_q    <= DevNone;
         heater_q <= 1'b0;
         ac_q     <= 1'b0;
         cooler_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= multi_req;
         unique case (state_q)
            StIdle: begin
               if (one_req) begin
                  state_q  <= StRun;
                  dev_q    <= req_dev;
                  heater_q <= heater_req;
                  ac_q     <= ac_req;
                  cooler_q <= cooler_req;
                  busy_q   <= 1'b1;
               end
            end
            StRun: begin
               if (run_exit) begin
                  state_q  <= StDead;
                  dev_q    <= DevNone;
                  heater_q <= 1'b0;
                  ac_q     <= 1'b0;
                  cooler_q <= 1'b0;
               end
            end
            StDead: begin
               if (tmr_done) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q  <= StIdle;
               dev_q    <= DevNone;
               heater_q <= 1'b0;
               ac_q     <= 1'b0;
               cooler_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign heater_drive  = heater_q;
   assign ac_drive      = ac_q;
   assign cooler_drive  = cooler_q;
   assign busy          = busy_q;
   assign multi_req_err = err_q;

`ifdef ACTUATOR_GUARD_FAULT_CNT_EN
   logic [7:0] fault_q;

   // Counts alongside multi_req_err so both move on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 8'd0;
      end else if (multi_req && (fault_q != 8'hFF)) begin
         fault_q <= fault_q + 8'd1;
      end
   end

   assign fault_count = fault_q;
`endif

endmodule

// File: tb/tb_actuator_guard.sv
// Directed and random checks of actuator_guard with MIN_ON_CYCLES=4, DEAD_CYCLES=2.
module tb_actuator_guard;

   logic clk = 1'b0;
   logic reset, heater_req, ac_req, cooler_req;
   logic heater_drive, ac_drive, cooler_drive, busy, multi_req_err;
`ifdef ACTUATOR_GUARD_FAULT_CNT_EN
   logic [7:0] fault_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   actuator_guard #(
      .MIN_ON_CYCLES (4),
      .DEAD_CYCLES   (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .heater_req    (heater_req),
      .ac_req        (ac_req),
      .cooler_req    (cooler_req),
      .heater_drive  (heater_drive),
      .ac_drive      (ac_drive),
      .cooler_drive  (cooler_drive),
      .busy          (busy),
`ifdef ACTUATOR_GUARD_FAULT_CNT_EN
      .fault_count   (fault_count),
`endif
      .multi_req_err (multi_req_err)
   );

   // in = {reset, heater, ac, cooler}; exp = {heater, ac, cooler, busy, err}
   typedef struct {
      logic [3:0] in;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] in, input logic [4:0] exp, input int reps = 1);
      for (int i = 0; i < reps; i++) tbl.push_back('{in: in, exp: exp});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] in);
      {reset, heater_req, ac_req, cooler_req} = in;
   endtask

   initial begin
      logic [7:0] exp_fault;
      logic [2:0] r, drv, prev;
      int hi_len, lo_len, cnt;
      bit had_fall;

      drive(4'b1000);
      exp_fault = 8'd0;

      add(4'b1000, 5'b00000);       // reset
      add(4'b0000, 5'b00000);
      add(4'b0100, 5'b10010);       // one-cycle heater pulse
      add(4'b0000, 5'b10010, 3);    // held to min on-time
      add(4'b0000, 5'b00010);       // dead
      add(4'b0100, 5'b00010);       // request ignored in dead
      add(4'b0100, 5'b00000);       // idle regardless of request
      add(4'b0100, 5'b10010);       // heater starts
      add(4'b0110, 5'b10011, 3);    // ac joins, heater kept for min on
      add(4'b0110, 5'b00011);       // heater released
      add(4'b0010, 5'b00010);
      add(4'b0010, 5'b00000);
      add(4'b0010, 5'b01010, 6);    // ac runs while held
      add(4'b0000, 5'b00010, 2);
      add(4'b0000, 5'b00000);
      add(4'b0110, 5'b00001, 3);    // multi request from idle
      add(4'b0000, 5'b00000);
      add(4'b0111, 5'b00001);       // all three
      add(4'b0001, 5'b00110, 2);    // cooler runs
      add(4'b1001, 5'b00000);       // reset mid-run
      add(4'b0000, 5'b00000);
      add(4'b0001, 5'b00110);       // counters restart cleanly after reset
      add(4'b0000, 5'b00110, 3);
      add(4'b0000, 5'b00010);       // dead
      add(4'b1100, 5'b00000);       // reset mid-dead
      add(4'b0100, 5'b10010);       // no dead time after reset
      add(4'b1000, 5'b00000);
      add(4'b1110, 5'b00000);       // reset dominates multi request
      add(4'b0000, 5'b00000);

      foreach (tbl[i]) begin
         drive(tbl[i].in);
         step();
         if (tbl[i].in[3]) exp_fault = 8'd0;
         else if ($countones(tbl[i].in[2:0]) >= 2 && exp_fault != 8'hFF)
            exp_fault = exp_fault + 8'd1;
         check($sformatf("vec%0d", i),
               {27'd0, heater_drive, ac_drive, cooler_drive, busy, multi_req_err},
               {27'd0, tbl[i].exp});
`ifdef ACTUATOR_GUARD_FAULT_CNT_EN
         check($sformatf("vec%0d_fault", i), {24'd0, fault_count}, {24'd0, exp_fault});
`endif
      end

      // Cooler held for 20 cycles then dropped.
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         drive(4'b0001);
         step();
         if (cooler_drive) cnt++;
      end
      check("cooler_held_cycles", cnt, 20);
      drive(4'b0000);
      step();
      check("cooler_dead0", {30'd0, cooler_drive, busy}, 32'd1);
      step();
      check("cooler_dead1", {30'd0, cooler_drive, busy}, 32'd1);
      step();
      check("cooler_idle", {30'd0, cooler_drive, busy}, 32'd0);

      // Random requests with a protocol monitor.
      drive(4'b1000);
      step();
      r = 3'b000;
      prev = 3'b000;
      hi_len = 0;
      lo_len = 0;
      had_fall = 0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 2)] ^= 1'b1;
         drive({1'b0, r[0], r[2], r[1]});
         step();
         drv = {heater_drive, ac_drive, cooler_drive};
         check("rand_onehot", {31'd0, $countones(drv) > 1}, 32'd0);
         if (drv != 3'b000 && prev != 3'b000 && drv != prev)
            check("rand_switch", {29'd0, drv}, {29'd0, prev});
         if (drv != 3'b000) begin
            if (prev == 3'b000) begin
               if (had_fall) check("rand_gap_ge3", {31'd0, lo_len >= 3}, 32'd1);
               hi_len = 1;
            end else begin
               hi_len++;
            end
         end else begin
            if (prev != 3'b000) begin
               check("rand_pulse_ge4", {31'd0, hi_len >= 4}, 32'd1);
               had_fall = 1;
               lo_len = 1;
            end else begin
               lo_len++;
            end
         end
         prev = drv;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
